// File: rtl/mem_copy_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_copy_pkg
//  Purpose  : Shared definitions for the memory copy engine: default widths
//             of the memory address, data word and transfer length, plus the
//             copy FSM state enumeration.
//  Revision : 1.0  initial release
// ============================================================================
package mem_copy_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned LEN_W_DEFAULT  = 16;

    // One word moves as RD -> WAIT -> WR, so three cycles per word.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage : mem_copy_pkg
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : mem_copy_engine
//  Purpose  : Copies len consecutive words from src_addr to dst_addr through
//             a single-port data memory, one word per RD/WAIT/WR triple, in
//             ascending address order.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             start, abort    - begin a copy (IDLE only) / cancel a copy
//             src_addr,
//             dst_addr, len   - copy parameters, latched on accepted start
//             busy, done      - activity flag / one-cycle completion pulse
//             words_done      - words written in the current or last copy
//             read, wrt,
//             address,
//             data_in         - memory strobes, address and write data
//             data_out        - memory read data, valid the cycle after read
//  Revision : 1.0  initial release
// ============================================================================
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned LEN_W  = LEN_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic              wrt,
    output logic              read,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_words;
    logic [DATA_W-1:0]   r_data;

    logic [LEN_W-1:0]    w_words_inc;

    assign w_words_inc = r_words + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_words <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // abort has no meaning here, so start always wins.
                    if (start) begin
                        r_src   <= src_addr;
                        r_dst   <= dst_addr;
                        r_len   <= len;
                        r_words <= '0;
                        r_state <= (len != '0) ? ST_RD : ST_DONE;
                    end
                end
                ST_RD: begin
                    r_state <= abort ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    r_data  <= data_out;
                    r_state <= abort ? ST_IDLE : ST_WR;
                end
                ST_WR: begin
                    // The write strobe is already out this cycle, so the word
                    // lands in memory and is counted even if aborted here.
                    r_src   <= r_src + 1'b1;
                    r_dst   <= r_dst + 1'b1;
                    r_words <= w_words_inc;
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_words_inc < r_len) begin
                        r_state <= ST_RD;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore decode: memory-side outputs depend on state and registers only.
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign read       = (r_state == ST_RD);
    assign wrt        = (r_state == ST_WR);
    assign address    = (r_state == ST_RD) ? r_src :
                        (r_state == ST_WR) ? r_dst : '0;
    assign data_in    = (r_state == ST_WR) ? r_data : '0;
    assign words_done = r_words;

endmodule : mem_copy_engine
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_copy_engine
//  Purpose  : Self-checking bench for mem_copy_engine. A behavioural data
//             memory answers the engine; a reference copy model produces the
//             expected read addresses and write transactions, which a monitor
//             pops and compares as the engine issues them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_copy_engine;
    import mem_copy_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic        with_abort;  // drive abort together with start
        int          exp_lat;     // cycles from start cycle to done
        logic [15:0] exp_words;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] words_done;
    logic        wrt;
    logic        read;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on   = 1'b0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] mdl [logic [31:0]];
    logic [31:0] exp_rd [$];
    wr_t         exp_wr [$];

    mem_copy_engine dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .wrt        (wrt),
        .read       (read),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'd0;
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : 32'd0;
    endfunction

    // Data memory responder: registered read, write on the strobe edge.
    initial data_out = 32'd0;
    always @(posedge clk) if (read) data_out <= mem_rd(address);
    always @(posedge clk) if (wrt) mem[address] = data_in;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=%0h expected=none", name, act);
    endtask

    // Per-cycle monitor and scoreboard consumer.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("rd_wr_exclusive", {63'd0, read && wrt}, 64'd0);
            chk("busy_vs_state", {63'd0, busy}, {63'd0, dut.r_state != ST_IDLE});
            if (!busy || done) begin
                chk("idle_address", {32'd0, address}, 64'd0);
                chk("idle_data_in", {32'd0, data_in}, 64'd0);
                chk("idle_strobes", {62'd0, read, wrt}, 64'd0);
            end
            if (read) begin
                if (exp_rd.size() == 0) fail_now("unexpected_read", {32'd0, address});
                else chk("read_addr", {32'd0, address}, {32'd0, exp_rd.pop_front()});
            end
            if (wrt) begin
                if (exp_wr.size() == 0) begin
                    fail_now("unexpected_write", {32'd0, address});
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("write_addr", {32'd0, address}, {32'd0, e.addr});
                    chk("write_data", {32'd0, data_in}, {32'd0, e.data});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem[a] = d;
        mdl[a] = d;
    endtask

    // Reference copy: ascending, no overlap correction; first n words only.
    task automatic push_expected(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            wr_t w;
            logic [31:0] sa;
            logic [31:0] da;
            sa = s + i;
            da = d + i;
            exp_rd.push_back(sa);
            w.addr = da;
            w.data = mdl_rd(sa);
            mdl[da] = w.data;
            exp_wr.push_back(w);
        end
    endtask

    vec_t vecs [5];
    int   lat;
    logic [31:0] a;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;

        vecs[0] = '{src: 32'd3,          dst: 32'd20,  len: 16'd4, with_abort: 1'b0, exp_lat: 13, exp_words: 16'd4};
        vecs[1] = '{src: 32'd40,         dst: 32'd41,  len: 16'd0, with_abort: 1'b0, exp_lat: 1,  exp_words: 16'd0};
        vecs[2] = '{src: 32'hFFFF_FFFF,  dst: 32'd10,  len: 16'd2, with_abort: 1'b0, exp_lat: 7,  exp_words: 16'd2};
        vecs[3] = '{src: 32'd50,         dst: 32'd52,  len: 16'd4, with_abort: 1'b1, exp_lat: 13, exp_words: 16'd4};
        vecs[4] = '{src: 32'd700,        dst: 32'd800, len: 16'd1, with_abort: 1'b0, exp_lat: 4,  exp_words: 16'd1};

        for (int i = 0; i < 4; i++) preload(32'd3 + i, 32'd4 + i);
        preload(32'hFFFF_FFFF, 32'hA5A5_0001);
        preload(32'd0, 32'hA5A5_0002);
        for (int i = 0; i < 4; i++) preload(32'd50 + i, 32'h100 + i);
        preload(32'd700, 32'hCAFE_F00D);
        for (int i = 0; i < 8; i++) preload(32'd300 + i, 32'h300 + i);
        for (int i = 0; i < 5; i++) preload(32'd500 + i, 32'h500 + i);

        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_busy",  {63'd0, busy}, 64'd0);
        chk("reset_done",  {63'd0, done}, 64'd0);
        chk("reset_words", {48'd0, words_done}, 64'd0);
        chk("reset_strb",  {62'd0, read, wrt}, 64'd0);
        chk("reset_addr",  {32'd0, address}, 64'd0);
        chk("reset_din",   {32'd0, data_in}, 64'd0);
        mon_on = 1'b1;

        // abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", {63'd0, busy}, 64'd0);

        // Table-driven copies
        for (int v = 0; v < 5; v++) begin
            push_expected(vecs[v].src, vecs[v].dst, int'(vecs[v].len));
            start = 1'b1; abort = vecs[v].with_abort;
            src_addr = vecs[v].src; dst_addr = vecs[v].dst; len = vecs[v].len;
            tick();
            start = 1'b0; abort = 1'b0;
            lat = 1;
            while (!done && lat < 3 * int'(vecs[v].len) + 20) begin
                tick();
                lat++;
            end
            chk($sformatf("v%0d_done_seen", v), {63'd0, done}, 64'd1);
            chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
            chk($sformatf("v%0d_words", v), {48'd0, words_done}, {48'd0, vecs[v].exp_words});
            chk($sformatf("v%0d_busy_in_done", v), {63'd0, busy}, 64'd1);
            tick();
            chk($sformatf("v%0d_done_pulse", v), {62'd0, done, busy}, 64'd0);
            chk($sformatf("v%0d_rd_drained", v), 64'(exp_rd.size()), 64'd0);
            chk($sformatf("v%0d_wr_drained", v), 64'(exp_wr.size()), 64'd0);
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                a = vecs[v].dst + i;
                chk($sformatf("v%0d_mem_%0d", v, i), {32'd0, mem_rd(a)}, {32'd0, mdl_rd(a)});
            end
        end
        for (int i = 0; i < 4; i++) chk("basic_mem_const", {32'd0, mem_rd(32'd20 + i)}, 64'(4 + i));
        chk("len0_no_write", {63'd0, mem.exists(32'd41)}, 64'd0);
        chk("overlap_mem54", {32'd0, mem_rd(32'd54)}, 64'h100);
        chk("overlap_mem55", {32'd0, mem_rd(32'd55)}, 64'h101);

        // Abort during the second WAIT; start mid-copy must be ignored.
        push_expected(32'd300, 32'd400, 1);
        exp_rd.push_back(32'd301);
        start = 1'b1; src_addr = 32'd300; dst_addr = 32'd400; len = 16'd8;
        tick();  // cycle 1: RD
        start = 1'b0;
        tick();  // cycle 2: WAIT
        start = 1'b1; src_addr = 32'd900; dst_addr = 32'd950; len = 16'd3;
        tick();  // cycle 3: WR
        start = 1'b0;
        tick();  // cycle 4: RD
        tick();  // cycle 5: WAIT of word 2
        chk("abort_pre_busy", {63'd0, busy}, 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", {62'd0, busy, done}, 64'd0);
        chk("abort_words", {48'd0, words_done}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", {63'd0, done}, 64'd0);
        end
        chk("abort_wr_drained", 64'(exp_wr.size()), 64'd0);
        chk("abort_rd_drained", 64'(exp_rd.size()), 64'd0);
        chk("abort_mem400", {32'd0, mem_rd(32'd400)}, 64'h300);
        chk("abort_no_mem401", {63'd0, mem.exists(32'd401)}, 64'd0);
        chk("ignored_start_mem950", {63'd0, mem.exists(32'd950)}, 64'd0);

        // Reset asserted during WR of word 3.
        push_expected(32'd500, 32'd600, 3);
        start = 1'b1; src_addr = 32'd500; dst_addr = 32'd600; len = 16'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();  // now in cycle 9: WR of word 3
        chk("rst_pre_wrt", {63'd0, wrt}, 64'd1);
        rst = 1'b1;
        tick();
        chk("rst_outputs", {62'd0, busy, done}, 64'd0);
        chk("rst_strobes", {62'd0, read, wrt}, 64'd0);
        chk("rst_addr", {32'd0, address}, 64'd0);
        chk("rst_din", {32'd0, data_in}, 64'd0);
        chk("rst_words", {48'd0, words_done}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_no_activity", {61'd0, busy, done, wrt}, 64'd0);
        end
        chk("rst_wr_drained", 64'(exp_wr.size()), 64'd0);
        chk("rst_mem602", {32'd0, mem_rd(32'd602)}, 64'h502);
        chk("rst_no_mem603", {63'd0, mem.exists(32'd603)}, 64'd0);
        chk("rst_no_mem604", {63'd0, mem.exists(32'd604)}, 64'd0);

        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_mem_copy_engine
`default_nettype wire

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter ADDR_W, 32, width of word address to data_memory.
REQ-002 Parameter DATA_W, 32, width of memory data word.
REQ-003 Parameter LEN_W, 16, width of transfer length (words).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-006 start  input  1  single-cycle request to begin a copy; sampled only in IDLE.
REQ-007 src_addr  input  ADDR_W  first source word address; latched on accepted start.
REQ-008 dst_addr  input  ADDR_W  first destination word address; latched on accepted start.
REQ-009 len  input  LEN_W  number of words to copy; latched on accepted start.
REQ-010 abort  input  1  terminate an active copy.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on normal completion.
REQ-013 words_done  output  LEN_W  count of words written in current or last copy.
REQ-014 wrt  output  1  data_memory write strobe.
REQ-015 read  output  1  data_memory read strobe.
REQ-016 address  output  ADDR_W  data_memory address.
REQ-017 data_in  output  DATA_W  data_memory write data.
REQ-018 data_out  input  DATA_W  data_memory read data, valid in the cycle after read is high.

Function
REQ-019 States SHALL be IDLE, RD, WAIT, WR, DONE; wrt, read, address, data_in are decoded from state and registers only (Moore).
REQ-020 IDLE: start=1 with len!=0 -> RD, latch src/dst/len, clear words_done; start=1 with len=0 -> DONE with no memory access; else stay.
REQ-021 RD: read=1, wrt=0, address=current src pointer; -> WAIT.
REQ-022 WAIT: read=0, wrt=0; data_out captured into data register at end of cycle; -> WR.
REQ-023 WR: wrt=1, read=0, address=current dst pointer, data_in=captured word; at edge increment src, dst, words_done; -> RD if words_done+1 < len, else DONE.
REQ-024 DONE: done=1 for exactly one cycle, busy=1; -> IDLE.
REQ-025 Per-word cost SHALL be 3 cycles; start-to-done latency SHALL be 3*len+1 cycles (1 for len=0).
REQ-026 read and wrt SHALL never be high in the same cycle.
REQ-027 Address pointers SHALL increment by 1 per word and wrap modulo 2^ADDR_W without error.
REQ-028 start while busy SHALL be ignored; latched parameters unchanged.
REQ-029 abort=1 in RD, WAIT or WR -> IDLE at next edge, no done pulse, words_done holds words already written; abort in IDLE or DONE ignored.
REQ-030 abort and start in same IDLE cycle: start accepted, abort ignored.
REQ-031 In IDLE and DONE: wrt=0, read=0, address=0, data_in=0.
REQ-032 Overlapping source/destination ranges SHALL be copied in ascending order with no overlap correction.

Reset
REQ-033 rst=1 at any edge -> IDLE; busy, done, wrt, read=0, address, data_in, words_done, pointers, data register = 0.
REQ-034 Reset mid-copy SHALL produce no wrt in the cycle following the reset edge and no done pulse.
REQ-035 rst has priority over start and abort.

Structure
REQ-036 Shared package mem_copy_pkg SHALL hold the state enumeration and ADDR_W/DATA_W/LEN_W defaults.
REQ-037 No sub-module; single FSM with pointer and counter registers; bench instantiates data_memory as responder.

Verification
REQ-038 Preload mem[3..6]=4,5,6,7; start src=3 dst=20 len=4 -> mem[20..23]=4,5,6,7, done exactly 13 cycles after start edge, words_done=4.
REQ-039 start len=0 -> done next cycle, read and wrt never asserted, words_done=0.
REQ-040 src=0xFFFFFFFF dst=10 len=2 -> reads at 0xFFFFFFFF then 0, mem[10..11] written.
REQ-041 len=8, abort during second WAIT -> IDLE next edge, exactly 1 word written, no done; start during copy ignored.
REQ-042 len=5, rst asserted in WR of word 3 -> all outputs 0 after edge, no further wrt, mem beyond word 3 untouched.
REQ-043 Every cycle of every test: assert !(read && wrt) and busy==(state!=IDLE).
